// File: rtl/umult8_lane_seq.sv
// Purpose: walks LANES byte lanes of two latched operand words through one external umult8 and gathers the 16-bit products.
// Latency: start accepted at edge T -> done pulses in the cycle after edge T+LANES; result stays valid until the next start.
// Backpressure: none; start is honoured only in IDLE and ignored (not queued) while busy.
module umult8_lane_seq #(
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [0:8*LANES-1]    op_a,
    input  logic [0:8*LANES-1]    op_b,
    output logic [0:7]            mul_a,
    output logic [0:7]            mul_b,
    input  logic [0:15]           mul_p,
    output logic [0:16*LANES-1]   result,
    output logic                  busy,
    output logic                  done
);

    // A one-lane build still needs a 1-bit index so the counter has a legal width.
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [IDX_W-1:0]     lane_idx;
    logic [0:8*LANES-1]   op_a_q;
    logic [0:8*LANES-1]   op_b_q;
    logic                 accept;
    logic                 last_lane;

    assign accept    = (state == ST_IDLE) && start;
    assign last_lane = (lane_idx == LAST_IDX);

    // Sequencer: IDLE -> RUN on start, RUN for exactly LANES cycles, one DONE cycle, then back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)     state <= ST_RUN;
                ST_RUN:  if (last_lane) state <= ST_DONE;
                ST_DONE:                state <= ST_IDLE;
                default:                state <= ST_IDLE;
            endcase
        end
    end

    // Lane counter: cleared on acceptance, stepped once per RUN cycle, parked at 0 once the last lane is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_idx <= '0;
        end else if (accept) begin
            lane_idx <= '0;
        end else if (state == ST_RUN) begin
            if (last_lane) begin
                lane_idx <= '0;
            end else begin
                lane_idx <= lane_idx + 1'b1;
            end
        end
    end

    // Operand capture: the in-flight operation only ever sees the words present at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (accept) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
        end
    end

    // Result accumulation: cleared on acceptance, then the current lane's product lands in its 16-bit slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (accept) begin
            result <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_idx == IDX_W'(i)) begin
                    result[16*i +: 16] <= mul_p;
                end
            end
        end
    end

    // Multiplier feed: selected lane bytes during RUN, zero otherwise so umult8 sees quiet inputs when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == ST_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_idx == IDX_W'(i)) begin
                    mul_a = op_a_q[8*i +: 8];
                    mul_b = op_b_q[8*i +: 8];
                end
            end
        end
    end

    // Status decode straight from the state register; both drop the instant reset_n falls.
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DONE);
        done = (state == ST_DONE);
    end

endmodule
